serial_cmd_parser: RTL and testbench

SERIAL_CMD_PARSER -- requirements
Module: serial_cmd_parser

---
 rtl/serial_cmd_parser.sv | 187 ++++++++++++++++++
 tb/tb_serial_cmd_parser.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmd_parser.sv
// rtl/serial_cmd_parser.sv - serial command frame parser driving four motor control registers
//
// Accepts one byte per rising edge of rbyte_ready and parses frames of the form
// header, P0, P1, P2, P3 (plus a trailing XOR checksum byte when
// SERIAL_CMD_CHECKSUM_EN is defined). Header bits [3:0] select which motors are
// updated; a committed frame loads the selected ctrlN registers and pulses wr.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset_n      asynchronous active-low reset
//   rx_byte      received byte from the serial receiver
//   rbyte_ready  byte-valid level from the receiver (edge detected here)
//   ctrl0..3     registered control bytes for motors 0..3
//   wr           one-cycle write strobes, bit n for motor n
//   frame_ok     one-cycle pulse per committed frame
//   frame_err    one-cycle pulse per discarded frame or rejected header
//   frame_cnt    committed frame count, wraps 255 -> 0
//
// Optional feature macro: SERIAL_CMD_CHECKSUM_EN
module serial_cmd_parser #(
  parameter int TIMEOUT = 100000,
  parameter int CNT_W   = 17
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_byte,
  input  logic       rbyte_ready,
  output logic [7:0] ctrl0,
  output logic [7:0] ctrl1,
  output logic [7:0] ctrl2,
  output logic [7:0] ctrl3,
  output logic [3:0] wr,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] frame_cnt
);

`ifdef SERIAL_CMD_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, PAYLOAD, COMMIT, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, PAYLOAD, COMMIT} state_t;
`endif

  localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [3:0]       mask;
  logic [7:0]       shadow [4];
  logic [7:0]       pl [4];
  logic [CNT_W-1:0] gap;
  logic             rdy_q;
  logic             armed;
  logic             accept;
  logic             hdr_ok;
  logic             timeout;
  logic             load_hdr;
  logic             store_pl;
  logic             commit_go;
  logic             err_go;
`ifdef SERIAL_CMD_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  // armed stays low for the first cycle after reset so that a strobe already
  // high at release is absorbed into rdy_q instead of looking like an edge.
  assign accept  = rbyte_ready & ~rdy_q & armed;
  assign hdr_ok  = (rx_byte[7:4] == 4'h0) && (rx_byte[3:0] != 4'h0);
  // A byte landing in the same cycle the gap limit is reached keeps the frame.
  assign timeout = (gap == TO_C) && !accept;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load_hdr  = 1'b0;
    store_pl  = 1'b0;
    commit_go = 1'b0;
    err_go    = 1'b0;
    case (state)
      // COMMIT behaves like IDLE so a byte arriving there is taken as a header.
      IDLE, COMMIT: begin
        state_nxt = IDLE;
        if (accept) begin
          if (hdr_ok) begin
            load_hdr  = 1'b1;
            idx_nxt   = 2'd0;
            state_nxt = PAYLOAD;
          end else begin
            err_go = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          store_pl = 1'b1;
          idx_nxt  = idx + 2'd1;
          if (idx == 2'd3) begin
`ifdef SERIAL_CMD_CHECKSUM_EN
            state_nxt = CHECK;
`else
            commit_go = 1'b1;
            state_nxt = COMMIT;
`endif
          end
        end else if (timeout) begin
          err_go    = 1'b1;
          state_nxt = IDLE;
        end
      end
`ifdef SERIAL_CMD_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          if (rx_byte == csum) begin
            commit_go = 1'b1;
            state_nxt = COMMIT;
          end else begin
            err_go    = 1'b1;
            state_nxt = IDLE;
          end
        end else if (timeout) begin
          err_go    = 1'b1;
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow values including the byte being stored this cycle, so the commit of
  // the final payload byte can load ctrl in the very next cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pl[i] = (store_pl && (idx == 2'(i))) ? rx_byte : shadow[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      mask      <= 4'h0;
      rdy_q     <= 1'b0;
      armed     <= 1'b0;
      gap       <= '0;
      for (int i = 0; i < 4; i++) shadow[i] <= 8'h00;
      ctrl0     <= 8'h00;
      ctrl1     <= 8'h00;
      ctrl2     <= 8'h00;
      ctrl3     <= 8'h00;
      wr        <= 4'h0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= 8'h00;
`ifdef SERIAL_CMD_CHECKSUM_EN
      csum      <= 8'h00;
`endif
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      rdy_q <= rbyte_ready;
      armed <= 1'b1;
      if (load_hdr) mask <= rx_byte[3:0];
      for (int i = 0; i < 4; i++) shadow[i] <= pl[i];

      if (accept || (state == IDLE)) gap <= '0;
      else if (gap != TO_C)          gap <= gap + CNT_W'(1);

`ifdef SERIAL_CMD_CHECKSUM_EN
      if (load_hdr)      csum <= rx_byte;
      else if (store_pl) csum <= csum ^ rx_byte;
`endif

      wr        <= commit_go ? mask : 4'h0;
      frame_ok  <= commit_go;
      frame_err <= err_go;
      if (commit_go) begin
        frame_cnt <= frame_cnt + 8'd1;
        if (mask[0]) ctrl0 <= pl[0];
        if (mask[1]) ctrl1 <= pl[1];
        if (mask[2]) ctrl2 <= pl[2];
        if (mask[3]) ctrl3 <= pl[3];
      end
    end
  end

endmodule

// File: tb/tb_serial_cmd_parser.sv
// tb/tb_serial_cmd_parser.sv - scoreboard bench for serial_cmd_parser
module tb_serial_cmd_parser;

  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_byte;
  logic       rbyte_ready;
  logic [7:0] ctrl0, ctrl1, ctrl2, ctrl3;
  logic [3:0] wr;
  logic       frame_ok, frame_err;
  logic [7:0] frame_cnt;

  always #5 clk = ~clk;

  serial_cmd_parser #(.TIMEOUT(TO), .CNT_W(17)) dut (
    .clk(clk), .reset_n(reset_n), .rx_byte(rx_byte), .rbyte_ready(rbyte_ready),
    .ctrl0(ctrl0), .ctrl1(ctrl1), .ctrl2(ctrl2), .ctrl3(ctrl3),
    .wr(wr), .frame_ok(frame_ok), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic        err;
    logic [3:0]  wr;
    logic [31:0] ctrl;
    logic [7:0]  cnt;
    int          at;
  } ev_t;

  ev_t        q[$];
  ev_t        pend;
  bit         pend_v = 1'b0;
  int         cyc = 0;
  int         vec = 0;
  int         bad = 0;
  int         sp  = 20;
  logic [7:0] mctrl [4];
  logic [7:0] mcnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output events are matched in order against the scoreboard, including the
  // exact cycle they were due.
  always @(negedge clk) begin
    if (reset_n && (frame_ok || frame_err || (wr != 4'h0))) begin
      ev_t e;
      chk("ok_err_exclusive", 32'(frame_ok & frame_err), 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_event", {26'd0, wr, frame_ok, frame_err}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("ev_cycle", 32'(cyc), 32'(e.at));
        chk("ev_err", 32'(frame_err), 32'(e.err));
        chk("ev_ok", 32'(frame_ok), 32'(!e.err));
        chk("ev_wr", 32'(wr), 32'(e.wr));
        if (!e.err) begin
          chk("ev_ctrl", {ctrl3, ctrl2, ctrl1, ctrl0}, e.ctrl);
          chk("ev_cnt", 32'(frame_cnt), 32'(e.cnt));
        end
      end
    end
  end

  task automatic expect_commit(input logic [7:0] hdr, input logic [7:0] p0, input logic [7:0] p1,
                               input logic [7:0] p2, input logic [7:0] p3);
    if (hdr[0]) mctrl[0] = p0;
    if (hdr[1]) mctrl[1] = p1;
    if (hdr[2]) mctrl[2] = p2;
    if (hdr[3]) mctrl[3] = p3;
    mcnt      = mcnt + 8'd1;
    pend.err  = 1'b0;
    pend.wr   = hdr[3:0];
    pend.ctrl = {mctrl[3], mctrl[2], mctrl[1], mctrl[0]};
    pend.cnt  = mcnt;
    pend_v    = 1'b1;
  endtask

  task automatic expect_err();
    pend.err  = 1'b1;
    pend.wr   = 4'h0;
    pend.ctrl = 32'd0;
    pend.cnt  = 8'd0;
    pend_v    = 1'b1;
  endtask

  // Drives one byte; a pending expectation becomes due one cycle after the
  // edge that samples this byte.
  task automatic send_byte(input logic [7:0] b, input int hold, output int d);
    @(negedge clk);
    rx_byte     = b;
    rbyte_ready = 1'b1;
    d           = cyc;
    if (pend_v) begin
      pend.at = cyc + 1;
      q.push_back(pend);
      pend_v  = 1'b0;
    end
    repeat (hold) @(negedge clk);
    rbyte_ready = 1'b0;
    repeat (sp) @(negedge clk);
  endtask

  task automatic send_tail(input logic [7:0] hdr, input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] p3, input int hold, input bit badcs);
    int d;
`ifdef SERIAL_CMD_CHECKSUM_EN
    send_byte(p3, hold, d);
    if (badcs) expect_err();
    else       expect_commit(hdr, p0, p1, p2, p3);
    send_byte(hdr ^ p0 ^ p1 ^ p2 ^ p3 ^ (badcs ? 8'h07 : 8'h00), hold, d);
`else
    if (badcs) expect_err();
    else       expect_commit(hdr, p0, p1, p2, p3);
    send_byte(p3, hold, d);
`endif
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3, input int hold, input bit badcs);
    int d;
    send_byte(hdr, hold, d);
    send_byte(p0, hold, d);
    send_byte(p1, hold, d);
    send_byte(p2, hold, d);
    send_tail(hdr, p0, p1, p2, p3, hold, badcs);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mctrl[i] = 8'h00;
    mcnt = 8'h00;
  endtask

  initial begin
    int d;
    int n;
    reset_n     = 1'b0;
    rx_byte     = 8'h00;
    rbyte_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {ctrl3, ctrl2, ctrl1, ctrl0}, 32'd0);
    chk("reset_wr", 32'(wr), 32'd0);
    chk("reset_ok", 32'(frame_ok), 32'd0);
    chk("reset_err", 32'(frame_err), 32'd0);
    chk("reset_cnt", 32'(frame_cnt), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // All four motors updated in one frame.
    send_frame(8'h0F, 8'h11, 8'h22, 8'h33, 8'h44, 1, 1'b0);
    chk("all_motor_ctrl", {ctrl3, ctrl2, ctrl1, ctrl0}, 32'h44332211);

    // Repeated single-motor zero frames.
    for (int i = 0; i < 10; i++) send_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1'b0);
    chk("ten_frames_ctrl0", 32'(ctrl0), 32'h00);
    chk("ten_frames_cnt", 32'(frame_cnt), 32'(mcnt));

    // Rejected headers, then a good frame proves the parser resynced in IDLE.
    expect_err();
    send_byte(8'h00, 1, d);
    expect_err();
    send_byte(8'h25, 1, d);
    send_frame(8'h04, 8'h01, 8'h02, 8'h77, 8'h03, 1, 1'b0);
    chk("resync_ctrl2", 32'(ctrl2), 32'h77);

    // Inter-byte timeout discards the partial frame.
    send_byte(8'h03, 1, d);
    send_byte(8'hAA, 1, d);
    send_byte(8'hBB, 1, d);
    pend.err = 1'b1; pend.wr = 4'h0; pend.ctrl = 32'd0; pend.cnt = 8'd0;
    pend.at  = d + 2 + TO;
    q.push_back(pend);
    repeat (TO + 20) @(negedge clk);
    chk("timeout_drained", 32'(q.size()), 32'd0);
    send_frame(8'h02, 8'h00, 8'h5C, 8'h00, 8'h00, 1, 1'b0);
    chk("after_timeout_ctrl", {ctrl3, ctrl2, ctrl1, ctrl0}, {mctrl[3], mctrl[2], 8'h5C, mctrl[0]});

    // A byte arriving exactly when the gap counter reaches the limit keeps the frame.
    send_byte(8'h09, 1, d);
    send_byte(8'h66, 1, d);
    while (cyc < d + TO) @(negedge clk);
    send_byte(8'h55, 1, d);
    send_byte(8'h44, 1, d);
    send_tail(8'h09, 8'h66, 8'h55, 8'h44, 8'h99, 1, 1'b0);

    // Held-high strobes behave like single-cycle strobes.
    send_frame(8'h0A, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 5, 1'b0);
    chk("held_ctrl", {ctrl3, ctrl2, ctrl1, ctrl0}, {mctrl[3], mctrl[2], mctrl[1], mctrl[0]});

    // Frame counter wraps through zero.
    sp = 3;
    n  = 256 - int'(mcnt);
    for (int i = 0; i < n; i++) send_frame(8'h01, 8'(i), 8'h00, 8'h00, 8'h00, 1, 1'b0);
    chk("cnt_wrap", 32'(frame_cnt), 32'd0);
    send_frame(8'h01, 8'h3C, 8'h00, 8'h00, 8'h00, 1, 1'b0);
    chk("cnt_after_wrap", 32'(frame_cnt), 32'd1);
    sp = 20;

    // Reset during P2 aborts silently; a strobe high at release is ignored.
    send_byte(8'h0F, 1, d);
    send_byte(8'h11, 1, d);
    send_byte(8'h22, 1, d);
    @(negedge clk);
    rx_byte     = 8'h33;
    rbyte_ready = 1'b1;
    reset_n     = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midreset_ctrl", {ctrl3, ctrl2, ctrl1, ctrl0}, 32'd0);
    chk("midreset_outs", {22'd0, wr, frame_ok, frame_err, frame_cnt}, 32'd0);
    rx_byte = 8'h01;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    rbyte_ready = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h0F, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 1, 1'b0);
    chk("post_reset_ctrl", {ctrl3, ctrl2, ctrl1, ctrl0}, 32'hA4A3A2A1);
    chk("post_reset_cnt", 32'(frame_cnt), 32'd1);

`ifdef SERIAL_CMD_CHECKSUM_EN
    send_frame(8'h01, 8'h12, 8'h00, 8'h00, 8'h00, 1, 1'b0);
    chk("csum_good_ctrl0", 32'(ctrl0), 32'h12);
    send_frame(8'h01, 8'h12, 8'h00, 8'h00, 8'h00, 1, 1'b1);
    chk("csum_bad_cnt", 32'(frame_cnt), 32'(mcnt));
`endif

    n = 0;
    while ((q.size() != 0) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("final_ctrl", {ctrl3, ctrl2, ctrl1, ctrl0}, {mctrl[3], mctrl[2], mctrl[1], mctrl[0]});
    chk("final_cnt", 32'(frame_cnt), 32'(mcnt));

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
